// File: rtl/uart_tx_parity_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_parity_if
//  Description : Byte-request / serial-line bundle for the parity UART
//                transmitter. The host side (master) offers a byte with a
//                one-cycle start request and observes line/status outputs.
//                The transmitter side (slave) consumes the request and drives
//                the serial line and status.
//  Signals     : tx_start  host -> tx   request to send tx_data
//                tx_data   host -> tx   byte to send (8 bits)
//                tx        tx -> host   serial line, idle/stop = 1
//                tx_busy   tx -> host   frame in progress
//                tx_done   tx -> host   one-cycle pulse at end of stop bit
//                tx_pbit   tx -> host   parity bit of the captured byte
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_parity_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_pbit;

  modport master (
    output tx_start,
    output tx_data,
    input  tx,
    input  tx_busy,
    input  tx_done,
    input  tx_pbit
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx,
    output tx_busy,
    output tx_done,
    output tx_pbit
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_parity.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_parity
//  Description : UART transmitter. Serialises one byte per accepted request
//                into start bit, 8 data bits (LSB first), optional parity
//                bit and one stop bit. Parity uses the same rule as the
//                receive-side checker: even -> ^data, odd -> ~^data.
//  Parameters  : CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//                PARITY_EN     1: parity bit between data and stop
//                PARITY_ODD    0: even parity, 1: odd parity
//  Ports       : clk  system clock, rising edge
//                rst  synchronous reset, active-high, highest priority
//                bus  uart_tx_parity_if.slave (tx_start, tx_data in;
//                     tx, tx_busy, tx_done, tx_pbit out)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_parity #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  uart_tx_parity_if.slave  bus
);

  // Counter only needs to reach CLKS_PER_BIT-1.
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
  localparam logic             ODD_INV   = (PARITY_ODD != 0);
  localparam logic             HAS_PAR   = (PARITY_EN != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
  logic             r_pbit;

  logic             w_bit_end;
  logic [2:0]       w_next_idx;

  assign w_bit_end  = (r_baud_cnt == BAUD_LAST);
  assign w_next_idx = r_bit_idx + 3'd1;

  // The line value is registered one cycle ahead: whenever a bit cell ends,
  // tx is loaded with the value of the following cell, so each cell appears
  // on the pad for exactly CLKS_PER_BIT cycles with no combinational path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pbit     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (bus.tx_start) begin
            r_shift    <= bus.tx_data;
            r_pbit     <= (^bus.tx_data) ^ ODD_INV;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_state    <= S_START;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_state    <= S_DATA;
            r_tx       <= r_shift[0];
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_ONE;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              if (HAS_PAR) begin
                r_state <= S_PARITY;
                r_tx    <= r_pbit;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_idx <= w_next_idx;
              r_tx      <= r_shift[w_next_idx];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_ONE;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_state    <= S_STOP;
            r_tx       <= 1'b1;
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_ONE;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            // Landing in IDLE here lets a request in the tx_done cycle be
            // accepted, giving back-to-back frames with no idle bit.
            r_baud_cnt <= '0;
            r_state    <= S_IDLE;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_tx       <= 1'b1;
          end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_ONE;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_baud_cnt <= '0;
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx      = r_tx;
  assign bus.tx_busy = r_busy;
  assign bus.tx_done = r_done;
  assign bus.tx_pbit = r_pbit;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_parity.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_parity
//  Description : Self-checking bench for uart_tx_parity. Three instances with
//                different parameter sets (even parity / no parity / odd
//                parity at minimum bit time) are driven from one directed
//                sequence; every cycle of each frame is compared against a
//                frame built from the serial framing rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_parity;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = 3'b000;
  logic [7:0] data_v [3];

  always #5 clk = ~clk;

  uart_tx_parity_if bus0 ();
  uart_tx_parity_if bus1 ();
  uart_tx_parity_if bus2 ();

  assign bus0.tx_start = start_v[0];
  assign bus1.tx_start = start_v[1];
  assign bus2.tx_start = start_v[2];
  assign bus0.tx_data  = data_v[0];
  assign bus1.tx_data  = data_v[1];
  assign bus2.tx_data  = data_v[2];

  logic [2:0] tx_o, busy_o, done_o, pbit_o;
  assign tx_o   = {bus2.tx,      bus1.tx,      bus0.tx};
  assign busy_o = {bus2.tx_busy, bus1.tx_busy, bus0.tx_busy};
  assign done_o = {bus2.tx_done, bus1.tx_done, bus0.tx_done};
  assign pbit_o = {bus2.tx_pbit, bus1.tx_pbit, bus0.tx_pbit};

  uart_tx_parity #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  uart_tx_parity #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  uart_tx_parity #(.CLKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(1))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Reference configuration of each instance.
  int cpb_t  [3] = '{4, 4, 2};
  bit pen_t  [3] = '{1'b1, 1'b0, 1'b1};
  bit podd_t [3] = '{1'b0, 1'b0, 1'b1};

  int errors = 0;
  int checks = 0;

  task automatic chk(input int d, input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL dut%0d %s observed=%b expected=%b t=%0t", d, tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame: start, data LSB first, optional parity, stop.
  task automatic build_frame(input int d, input logic [7:0] data, output logic bits[$]);
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (pen_t[d]) bits.push_back((^data) ^ podd_t[d]);
    bits.push_back(1'b1);
  endtask

  // Called 1 time unit after the acceptance edge. Checks every cycle of the
  // frame and the tx_done cycle. Optionally pulses a request mid-frame
  // (ign_at >= 0) and/or raises a new request in the last stop cycle so it
  // is held through tx_done (chain).
  task automatic check_frame(input int d, input logic [7:0] data, input int ign_at,
                             input bit chain, input logic [7:0] nxt);
    logic bits[$];
    int   len;
    logic exp_p;
    build_frame(d, data, bits);
    len   = bits.size() * cpb_t[d];
    exp_p = (^data) ^ podd_t[d];
    for (int k = 0; k < len; k++) begin
      chk(d, $sformatf("tx[c%0d]", k), tx_o[d], bits[k / cpb_t[d]]);
      chk(d, "busy", busy_o[d], 1'b1);
      chk(d, "done_early", done_o[d], 1'b0);
      chk(d, "pbit", pbit_o[d], exp_p);
      if (!start_v[d] || k == ign_at + 1) begin
        start_v[d] = 1'b0;
        data_v[d]  = 8'($urandom);
      end
      if (k == ign_at) begin
        start_v[d] = 1'b1;
        data_v[d]  = 8'h3C;
      end
      if (chain && k == len - 1) begin
        start_v[d] = 1'b1;
        data_v[d]  = nxt;
      end
      tick();
    end
    chk(d, "done_pulse", done_o[d], 1'b1);
    chk(d, "busy_at_done", busy_o[d], 1'b0);
    chk(d, "tx_at_done", tx_o[d], 1'b1);
    chk(d, "pbit_at_done", pbit_o[d], exp_p);
    tick();
    if (chain) begin
      start_v[d] = 1'b0;
      data_v[d]  = 8'($urandom);
    end else begin
      chk(d, "done_cleared", done_o[d], 1'b0);
      chk(d, "idle_tx", tx_o[d], 1'b1);
      chk(d, "idle_busy", busy_o[d], 1'b0);
    end
  endtask

  task automatic send(input int d, input logic [7:0] data, input int ign_at);
    start_v[d] = 1'b1;
    data_v[d]  = data;
    tick();
    start_v[d] = 1'b0;
    data_v[d]  = 8'($urandom);
    check_frame(d, data, ign_at, 1'b0, 8'h00);
  endtask

  initial begin
    logic bits[$];
    logic [7:0] rd;
    data_v[0] = 8'h00;
    data_v[1] = 8'h00;
    data_v[2] = 8'h00;

    // Reset with requests asserted: reset must win.
    rst     = 1'b1;
    start_v = 3'b111;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      chk(d, "rst_tx", tx_o[d], 1'b1);
      chk(d, "rst_busy", busy_o[d], 1'b0);
      chk(d, "rst_done", done_o[d], 1'b0);
      chk(d, "rst_pbit", pbit_o[d], 1'b0);
    end
    start_v = 3'b000;
    rst     = 1'b0;
    repeat (2) tick();

    // Even parity, 0xA5.
    send(0, 8'hA5, -1);
    // 0x07 with even and odd parity.
    send(0, 8'h07, -1);
    send(2, 8'h07, -1);
    // No parity, 0xFF.
    send(1, 8'hFF, -1);
    // Request mid-DATA ignored, then request held through tx_done.
    start_v[0] = 1'b1;
    data_v[0]  = 8'h81;
    tick();
    start_v[0] = 1'b0;
    check_frame(0, 8'h81, 4 * 3 + 1, 1'b1, 8'h18);
    check_frame(0, 8'h18, -1, 1'b0, 8'h00);

    // Reset during data bit 3 aborts the frame.
    start_v[0] = 1'b1;
    data_v[0]  = 8'hC3;
    tick();
    start_v[0] = 1'b0;
    build_frame(0, 8'hC3, bits);
    for (int k = 0; k < 4 * 4 + 2; k++) begin
      chk(0, "pre_abort_tx", tx_o[0], bits[k / 4]);
      tick();
    end
    rst = 1'b1;
    tick();
    chk(0, "abort_tx", tx_o[0], 1'b1);
    chk(0, "abort_busy", busy_o[0], 1'b0);
    chk(0, "abort_done", done_o[0], 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      chk(0, "post_abort_done", done_o[0], 1'b0);
      chk(0, "post_abort_tx", tx_o[0], 1'b1);
      tick();
    end
    send(0, 8'h5A, -1);

    // Random bytes across all configurations, some with mid-frame requests.
    for (int i = 0; i < 9; i++) begin
      rd = 8'($urandom);
      send(i % 3, rd, (i % 2 == 1) ? int'($urandom_range(0, 15)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
